uart_rx: RTL and testbench
==========================

Name: uart_rx

Overview:
- 8N1 UART receiver, the downstream consumer of the serial line driven by the team's UART transmitter.
- Synchronises the asynchronous RX pin, detects the start bit and samples each bit at mid-bit.
- Assembles the byte LSB-first and presents it with a rdy/clr_rdy handshake plus framing and overrun status.
- Default baud is 115200 at 50 MHz, the same timing as the transmitter, so the two can be looped back directly.

Parameters:
- BAUD_CNT, 434: clocks per bit period.
- HALF_CNT, 217: clocks from start-edge detect to the start-bit sample. Must be < BAUD_CNT.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  reset, asynchronous, active-high; the block's only reset.
- RX  input  1  asynchronous serial line; idles high.
- clr_rdy  input  1  consumer acknowledge. Clears rdy, frame_err and overrun.
- rx_data  output  8  last received byte; changes only at frame completion.
- rdy  output  1  byte available in rx_data.
- frame_err  output  1  stop bit of the last completed frame sampled 0.
- overrun  output  1  a frame completed while rdy was still 1. Sticky.
- busy  output  1  high whenever the state machine is not in IDLE.

Behaviour:
- Clock and reset:
  - Single clock, clk.
  - rst asserted: all flops asynchronously take reset values.
  - Reset values: sync flops = 1, state = IDLE, rx_data = 8'h00, rdy = 0, frame_err = 0, overrun = 0, busy = 0.
  - Reset mid-frame abandons the frame; no rdy results.
- Synchroniser:
  - RX passes through 2 flops, then 1 history flop.
  - Falling edge = history 1 and synced 0. It is recognised 3 clocks after the pin falls.
- Bit timing:
  - Counter width is clog2(BAUD_CNT).
  - Sample k (k = 0 start, 1..8 data, 9 stop) occurs exactly HALF_CNT + k*BAUD_CNT clocks after the edge-detect cycle.
  - The counter is idle (held) in IDLE.
- State machine:
  - IDLE: on falling edge -> START; load counter for HALF_CNT; busy = 1.
  - START: at sample 0, if synced RX = 1 (false start/glitch) -> IDLE with no flags changed; else -> DATA, bit_cnt = 0.
  - DATA:
    - At each sample, shift register <= {RX, shreg[7:1]} and bit_cnt++.
    - After the 8th data sample (bit_cnt reaches 8) -> STOP.
  - STOP: at sample 9 -> IDLE; in the same cycle:
    - rx_data <= shreg.
    - rdy <= 1.
    - frame_err <= ~RX_sync.
    - overrun <= overrun | rdy_old.
- Framing error: the byte is still delivered. Return to IDLE is unconditional; since detection is edge-based, a line held low (break) does not retrigger until it rises and falls again.
- Handshake:
  - clr_rdy clears rdy, frame_err and overrun the next cycle.
  - clr_rdy in the same cycle as frame completion: set wins, and overrun is computed from rdy before the clear.
  - rdy is not cleared by a new start bit.
- Back-to-back frames: a falling edge is accepted on the first IDLE cycle after STOP, so zero extra idle time between frames is supported.
- No FIFO: overrun loses the earlier byte; rx_data holds the newest.

Decomposition:
- Shared package uart_pkg:
  - State enum rx_state_t {IDLE, START, DATA, STOP}.
  - Default BAUD_CNT/HALF_CNT constants, shared with the transmitter so both ends agree.
- One natural sub-module: uart_rx_sync (2-flop synchroniser + edge detect; outputs rx_sync, fall_edge).
- Counter, shifter and FSM stay in uart_rx.

Test Plan:
- Loopback from the team's UART transmitter sending 8'hA5 -> one rdy pulse-to-level ~10*434 clocks later; rx_data = 8'hA5, frame_err = 0, overrun = 0.
- Low glitch of 100 clocks on RX -> START rejects at sample 0; busy returns 0; rdy stays 0; rx_data unchanged.
- Frame 8'h3C with stop bit driven 0 -> rdy = 1, rx_data = 8'h3C, frame_err = 1. Hold RX low 2000 clocks -> no new frame until RX rises and falls.
- Back-to-back 8'h00 then 8'hFF with zero idle, no clr_rdy -> rx_data = 8'hFF, rdy = 1, overrun = 1. clr_rdy -> all three flags 0 next cycle.
- clr_rdy asserted in the exact completion cycle of a frame -> rdy stays 1 (set wins), overrun = 0.
- rst asserted during data bit 4 of 8'h55, released 50 clocks later -> all outputs at reset values, no rdy. The next frame 8'hC3 is received correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// uart_pkg: timing constants and receiver state encoding shared by the
// UART transmitter and receiver so both ends of a link agree on baud.
package uart_pkg;

   // 115200 baud from a 50 MHz clock
   localparam int UART_BAUD_CNT = 434;
   localparam int UART_HALF_CNT = 217;

   typedef enum logic [1:0] {
      IDLE,
      START,
      DATA,
      STOP
   } rx_state_t;

endpackage

// File: rtl/uart_rx_sync.sv
// uart_rx_sync: two-flop synchroniser for the serial line plus a history
// flop for falling-edge detection.
// Ports: clk, rst (async high) | rx (async pin) | rx_sync, fall_edge.
module uart_rx_sync (
   input  logic clk,
   input  logic rst,
   input  logic rx,
   output logic rx_sync,
   output logic fall_edge
);

   logic meta;
   logic hist;

   // Line idles high, so every stage resets to 1 to avoid a false edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         meta    <= 1'b1;
         rx_sync <= 1'b1;
         hist    <= 1'b1;
      end else begin
         meta    <= rx;
         rx_sync <= meta;
         hist    <= rx_sync;
      end
   end

   assign fall_edge = hist & ~rx_sync;

endmodule

// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver with mid-bit sampling, LSB-first assembly,
// rdy/clr_rdy handshake, framing-error and sticky overrun status.
// Ports: clk, rst (async high) | RX (serial in) | clr_rdy (ack)
//        rx_data[7:0], rdy, frame_err, overrun, busy.
module uart_rx
   import uart_pkg::*;
#(
   parameter int BAUD_CNT = UART_BAUD_CNT,
   parameter int HALF_CNT = UART_HALF_CNT
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       RX,
   input  logic       clr_rdy,
   output logic [7:0] rx_data,
   output logic       rdy,
   output logic       frame_err,
   output logic       overrun,
   output logic       busy
);

   localparam int CW = $clog2(BAUD_CNT);
   localparam logic [CW-1:0] HALF_LD = CW'(HALF_CNT - 1);
   localparam logic [CW-1:0] BAUD_LD = CW'(BAUD_CNT - 1);

   rx_state_t     state;
   rx_state_t     state_nx;
   logic [CW-1:0] cnt;
   logic [3:0]    bit_cnt;
   logic [7:0]    shreg;
   logic          rx_sync;
   logic          fall_edge;
   logic          tick;
   logic          done;

   uart_rx_sync u_sync (
      .clk       (clk),
      .rst       (rst),
      .rx        (RX),
      .rx_sync   (rx_sync),
      .fall_edge (fall_edge)
   );

   // Sample strobe: counter expires while a frame is in progress.
   assign tick = (state != IDLE) && (cnt == '0);
   assign busy = (state != IDLE);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      done     = 1'b0;
      unique case (state)
         IDLE:  if (fall_edge) state_nx = START;
         START: if (tick) state_nx = rx_sync ? IDLE : DATA;
         DATA:  if (tick && bit_cnt == 4'd7) state_nx = STOP;
         STOP:  if (tick) begin
                   state_nx = IDLE;
                   done     = 1'b1;
                end
         default: state_nx = IDLE;
      endcase
   end

   // Loaded with HALF-1 at the edge so sample 0 lands HALF clocks later;
   // reloaded with BAUD-1 after every sample.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)                cnt <= '0;
      else if (state == IDLE) begin
         if (fall_edge)       cnt <= HALF_LD;
      end else if (tick)      cnt <= BAUD_LD;
      else                    cnt <= cnt - CW'(1);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bit_cnt <= '0;
         shreg   <= '0;
      end else if (tick && state == START) begin
         bit_cnt <= '0;
      end else if (tick && state == DATA) begin
         shreg   <= {rx_sync, shreg[7:1]};
         bit_cnt <= bit_cnt + 4'd1;
      end
   end

   // Completion beats a simultaneous clr_rdy; overrun uses the old rdy.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rx_data   <= '0;
         rdy       <= 1'b0;
         frame_err <= 1'b0;
         overrun   <= 1'b0;
      end else if (done) begin
         rx_data   <= shreg;
         rdy       <= 1'b1;
         frame_err <= ~rx_sync;
         overrun   <= overrun | rdy;
      end else if (clr_rdy) begin
         rdy       <= 1'b0;
         frame_err <= 1'b0;
         overrun   <= 1'b0;
      end
   end

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: randomized and directed self-checking bench for uart_rx,
// acting as the transmitter on RX and tracking expected status in a model.
module tb_uart_rx;

   localparam int B   = 40;
   localparam int H   = 20;
   // pin launch -> rdy: 3 clocks to edge detect, then sample 9 at H+9B
   localparam int LAT = 3 + H + 9 * B;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       RX = 1'b1;
   logic       clr_rdy = 1'b0;
   logic [7:0] rx_data;
   logic       rdy;
   logic       frame_err;
   logic       overrun;
   logic       busy;

   int n_chk = 0;
   int n_pass = 0;
   int cyc = 0;
   int rise_cyc = -1;
   int rise_n = 0;
   int r0;
   logic rdy_q = 1'b0;

   logic [7:0] m_data = 8'h00;
   logic       m_rdy = 1'b0;
   logic       m_ferr = 1'b0;
   logic       m_ovr = 1'b0;

   uart_rx #(
      .BAUD_CNT (B),
      .HALF_CNT (H)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .RX        (RX),
      .clr_rdy   (clr_rdy),
      .rx_data   (rx_data),
      .rdy       (rdy),
      .frame_err (frame_err),
      .overrun   (overrun),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (rdy && !rdy_q) begin
         rise_cyc = cyc;
         rise_n   = rise_n + 1;
      end
      rdy_q = rdy;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   task automatic check_out(input string tag);
      check({tag, "_data"}, rx_data, m_data);
      check({tag, "_rdy"}, rdy, m_rdy);
      check({tag, "_ferr"}, frame_err, m_ferr);
      check({tag, "_ovr"}, overrun, m_ovr);
   endtask

   // Called at #1 after a posedge; each bit lasts B clocks.
   task automatic send_frame(input logic [7:0] d, input logic stop,
                             input int nbits);
      logic [9:0] f;
      int         launch;
      logic       was_rdy;
      f       = {stop, d, 1'b0};
      launch  = cyc;
      was_rdy = m_rdy;
      for (int k = 0; k < nbits; k++) begin
         RX = f[k];
         repeat (B) @(posedge clk);
         #1;
      end
      if (nbits == 10) begin
         m_ovr  = m_ovr | m_rdy;
         m_rdy  = 1'b1;
         m_data = d;
         m_ferr = ~stop;
         if (!was_rdy) check("latency", rise_cyc - launch, LAT);
      end
   endtask

   task automatic clear(input string tag);
      clr_rdy = 1'b1;
      @(posedge clk);
      #1;
      clr_rdy = 1'b0;
      m_rdy  = 1'b0;
      m_ferr = 1'b0;
      m_ovr  = 1'b0;
      check_out(tag);
   endtask

   task automatic idle(input int n);
      RX = 1'b1;
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Raise clr_rdy exactly in the completion cycle of a frame just launched.
   task automatic clr_at_done();
      repeat (LAT - 1) @(posedge clk);
      #1;
      clr_rdy = 1'b1;
      @(posedge clk);
      #1;
      clr_rdy = 1'b0;
   endtask

   initial begin
      logic [7:0] d;
      logic       s;

      repeat (3) @(posedge clk);
      #1;
      check_out("reset");
      check("reset_busy", busy, 0);
      rst = 1'b0;
      idle(10);

      send_frame(8'hA5, 1'b1, 10);
      check_out("a5");
      idle(5);
      clear("clr_a5");

      // short low glitch: start rejected at sample 0
      r0 = rise_n;
      RX = 1'b0;
      repeat (H / 2) @(posedge clk);
      #1;
      check("glitch_busy_hi", busy, 1);
      RX = 1'b1;
      idle(2 * B);
      check("glitch_busy_lo", busy, 0);
      check("glitch_rises", rise_n, r0);
      check_out("glitch");

      // framing error then a held-low break
      send_frame(8'h3C, 1'b0, 10);
      check_out("ferr");
      r0 = rise_n;
      repeat (2000) @(posedge clk);
      #1;
      check("break_busy", busy, 0);
      check("break_rises", rise_n, r0);
      clear("clr_ferr");
      idle(20);

      // back-to-back, no ack
      send_frame(8'h00, 1'b1, 10);
      send_frame(8'hFF, 1'b1, 10);
      check_out("b2b");
      idle(3);
      clear("clr_b2b");

      // ack in completion cycle, rdy previously 0
      fork
         send_frame(8'h96, 1'b1, 10);
         clr_at_done();
      join
      check_out("clr_same_cyc");
      // ack in completion cycle, rdy previously 1
      fork
         send_frame(8'h69, 1'b1, 10);
         clr_at_done();
      join
      check_out("clr_same_ovr");
      clear("clr_same");

      // reset during data bit 4 of 8'h55
      r0 = rise_n;
      send_frame(8'h55, 1'b1, 5);
      RX = 1'b1;
      repeat (H) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      m_data = 8'h00;
      m_rdy  = 1'b0;
      m_ferr = 1'b0;
      m_ovr  = 1'b0;
      check_out("mid_rst");
      check("mid_rst_busy", busy, 0);
      repeat (49) @(posedge clk);
      #1;
      rst = 1'b0;
      idle(2 * B);
      check("mid_rst_rises", rise_n, r0);
      check("mid_rst_busy2", busy, 0);
      send_frame(8'hC3, 1'b1, 10);
      check_out("c3");
      clear("clr_c3");

      for (int i = 0; i < 10; i++) begin
         d = 8'($urandom);
         s = ($urandom_range(0, 3) != 0);
         send_frame(d, s, 10);
         check_out("rand");
         if ($urandom_range(0, 1) == 1) clear("rand_clr");
         idle(s ? $urandom_range(0, B) : $urandom_range(1, B));
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
